div_seq: RTL and testbench

Sequencer between the EX-stage ALU and the iterative divider. It captures the operands of a DIV/DIVU, drives the divider's start/signed/operand/annul inputs, and stalls the pipeline while the divider runs. It presents the 64-bit {HI,LO} result for exactly one instruction and aborts the division cleanly on an exception flush.

---
 rtl/div_seq.sv | 201 ++++++++++++++++++++
 tb/tb_div_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: sequencer between the EX-stage ALU and the iterative divider.
// Captures DIV/DIVU operands, runs the divider under a watchdog, stalls the
// pipeline while it runs and presents {HI,LO} for exactly one instruction.
// Optional feature macro: DIV_ZERO_FAST_EN (zero divisor bypasses the divider).
module div_seq #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  output logic        div_annul_o,
  output logic        stall_o,
  output logic        hilo_valid_o,
  output logic [63:0] hilo_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Last RUN cycle value of cnt before the watchdog fires.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        signed_q, signed_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic        err_q, err_d;

  logic        accept_s;
  logic        fast_s;
  logic        timeout_s;

  assign accept_s  = start_i & ~flush_i;
  assign timeout_s = (cnt_q == CNT_LAST);

`ifdef DIV_ZERO_FAST_EN
  assign fast_s = (b_i == 32'h0000_0000);
`else
  assign fast_s = 1'b0;
`endif

  // State register: asynchronous reset to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush beats divider ready, which beats the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = fast_s ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (div_ready_i) begin
          state_d = DONE;
        end else if (timeout_s) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        // start_i is deliberately ignored here so the divide is not re-issued.
        if (flush_i) begin
          state_d = IDLE;
        end else if (!stall_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: operand capture, cycle count, result and error.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          a_d      = a_i;
          b_d      = b_i;
          signed_d = signed_i;
          cnt_d    = 8'd0;
          if (fast_s) begin
            res_d = {a_i, 32'hFFFF_FFFF};
            err_d = 1'b0;
          end else begin
            res_d = res_q;
            err_d = err_q;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 8'd1;
        if (flush_i) begin
          res_d = res_q;
        end else if (div_ready_i) begin
          res_d = div_result_i;
          err_d = 1'b0;
        end else if (timeout_s) begin
          res_d = 64'h0;
          err_d = 1'b1;
        end else begin
          res_d = res_q;
        end
      end
      DONE: begin
        res_d = res_q;
      end
      default: begin
        cnt_d = 8'd0;
      end
    endcase
  end

  // Datapath registers: asynchronous reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      signed_q <= 1'b0;
      cnt_q    <= 8'd0;
      res_q    <= 64'h0;
      err_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

  // Output decode; annul, stall and the flush masks react to the current cycle.
  always_comb begin
    div_signed_o = signed_q;
    div_a_o      = a_q;
    div_b_o      = b_q;
    hilo_o       = res_q;
    err_o        = err_q;
    div_start_o  = 1'b0;
    div_annul_o  = 1'b0;
    stall_o      = 1'b0;
    hilo_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        stall_o = accept_s & ~fast_s;
      end
      RUN: begin
        div_start_o = ~flush_i;
        div_annul_o = flush_i | (~div_ready_i & timeout_s);
        stall_o     = ~flush_i;
      end
      DONE: begin
        hilo_valid_o = ~flush_i;
      end
      default: begin
        stall_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq (default TIMEOUT = 64).
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, signed_i, flush_i, stall_i, div_ready_i;
  logic [31:0] a_i, b_i;
  logic [63:0] div_result_i;
  logic        div_start_o, div_signed_o, div_annul_o, stall_o, hilo_valid_o, err_o;
  logic [31:0] div_a_o, div_b_o;
  logic [63:0] hilo_o;

  int total_cnt = 0;
  int pass_cnt  = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam logic FAST = 1'b1;
`else
  localparam logic FAST = 1'b0;
`endif

  div_seq #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .stall_i(stall_i),
    .div_ready_i(div_ready_i), .div_result_i(div_result_i),
    .div_start_o(div_start_o), .div_signed_o(div_signed_o),
    .div_a_o(div_a_o), .div_b_o(div_b_o), .div_annul_o(div_annul_o),
    .stall_o(stall_o), .hilo_valid_o(hilo_valid_o), .hilo_o(hilo_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Runs cycles until hilo_valid_o; the divider model raises ready on the
  // ready_at-th cycle that div_start_o is high (0 = never).
  task automatic wait_done(input int ready_at, input logic [63:0] res,
                           output int runs, output int stalls,
                           output int annuls, output int annul_at);
    bit done = 1'b0;
    runs = 0; stalls = 0; annuls = 0; annul_at = 0;
    div_result_i = res;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (div_start_o) runs++;
      div_ready_i = div_start_o && (runs == ready_at);
      #1;
      if (stall_o) stalls++;
      if (div_annul_o) begin annuls++; annul_at = runs; end
      if (hilo_valid_o) done = 1'b1;
    end
    chk("wait_done_bound", {63'h0, done}, 64'h1);
  endtask

  int runs, stalls, annuls, annul_at, hv_cnt, st_cnt;

  initial begin
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
    div_ready_i = 1'b0; a_i = 32'h0; b_i = 32'h0; div_result_i = 64'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_start", {63'h0, div_start_o}, 64'h0);
    chk("rst_annul", {63'h0, div_annul_o}, 64'h0);
    chk("rst_stall", {63'h0, stall_o}, 64'h0);
    chk("rst_valid", {63'h0, hilo_valid_o}, 64'h0);
    chk("rst_hilo", hilo_o, 64'h0);
    chk("rst_ops", {div_a_o, div_b_o}, 64'h0);
    chk("rst_err_sgn", {62'h0, err_o, div_signed_o}, 64'h0);
    rst = 1'b0;

    // DIVU 100/7, ready on 34th RUN cycle (N = 33).
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd100; b_i = 32'd7;
    #1;
    chk("divu_c0_stall", {63'h0, stall_o}, 64'h1);
    chk("divu_c0_start", {63'h0, div_start_o}, 64'h0);
    wait_done(34, 64'h00000002_0000000E, runs, stalls, annuls, annul_at);
    chk("divu_runs", 64'(runs), 64'd34);
    chk("divu_stalls", 64'(stalls + 1), 64'd35);
    chk("divu_hilo", hilo_o, 64'h00000002_0000000E);
    chk("divu_err", {63'h0, err_o}, 64'h0);
    chk("divu_ops", {div_a_o, div_b_o}, {32'd100, 32'd7});
    chk("divu_done_stall", {63'h0, stall_o}, 64'h0);
    start_i = 1'b0;
    @(negedge clk); #1;
    chk("divu_valid_once", {63'h0, hilo_valid_o}, 64'h0);
    chk("divu_no_restart", {63'h0, div_start_o}, 64'h0);

    // DIV -7/2 with downstream stall held 3 cycles in DONE.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b1; a_i = 32'hFFFF_FFF9; b_i = 32'd2; stall_i = 1'b1;
    wait_done(3, 64'hFFFFFFFF_FFFFFFFD, runs, stalls, annuls, annul_at);
    chk("div_signed", {63'h0, div_signed_o}, 64'h1);
    hv_cnt = 1; st_cnt = 0;
    for (int d = 1; d < 4; d++) begin
      @(negedge clk);
      stall_i = (d < 3);
      #1;
      if (hilo_valid_o && hilo_o == 64'hFFFFFFFF_FFFFFFFD) hv_cnt++;
      if (div_start_o) st_cnt++;
    end
    chk("div_hold_cycles", 64'(hv_cnt), 64'd4);
    chk("div_no_reissue", 64'(st_cnt), 64'd0);
    start_i = 1'b0; stall_i = 1'b0;
    @(negedge clk); #1;
    chk("div_released", {62'h0, hilo_valid_o, div_start_o}, 64'h0);

    // DIVU 50/5 flushed in RUN cycle 10.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd50; b_i = 32'd5;
    annuls = 0; hv_cnt = 0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk); #1;
      if (div_annul_o) annuls++;
      if (hilo_valid_o) hv_cnt++;
    end
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    if (div_annul_o) annuls++;
    chk("flush_stall", {63'h0, stall_o}, 64'h0);
    chk("flush_start_drop", {63'h0, div_start_o}, 64'h0);
    @(negedge clk);
    flush_i = 1'b0; start_i = 1'b0;
    #1;
    if (div_annul_o) annuls++;
    if (hilo_valid_o) hv_cnt++;
    chk("flush_annul_once", 64'(annuls), 64'd1);
    chk("flush_no_valid", 64'(hv_cnt), 64'd0);
    chk("flush_idle", {62'h0, div_start_o, stall_o}, 64'h0);

    // Flush in cycle 0: nothing latched.
    @(negedge clk);
    start_i = 1'b1; a_i = 32'd77; b_i = 32'd9; flush_i = 1'b1;
    #1;
    chk("flush0_stall", {63'h0, stall_o}, 64'h0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("flush0_idle", {63'h0, div_start_o}, 64'h0);
    chk("flush0_nolatch", {div_a_o, div_b_o}, {32'd50, 32'd5});

    // Watchdog: divider never ready.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd1; b_i = 32'd3;
    wait_done(0, 64'h0, runs, stalls, annuls, annul_at);
    chk("wd_runs", 64'(runs), 64'd64);
    chk("wd_annul_once", 64'(annuls), 64'd1);
    chk("wd_annul_at", 64'(annul_at), 64'd64);
    chk("wd_hilo", hilo_o, 64'h0);
    chk("wd_err", {63'h0, err_o}, 64'h1);
    start_i = 1'b0;
    @(negedge clk);

    // DIV 5/0: fast path when enabled, otherwise a normal RUN.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b1; a_i = 32'd5; b_i = 32'd0;
    #1;
    chk("dz_c0_stall", {63'h0, stall_o}, {63'h0, ~FAST});
    @(negedge clk);
    div_result_i = 64'h00000005_FFFFFFFF;
    div_ready_i = div_start_o;
    #1;
    chk("dz_c1_start", {63'h0, div_start_o}, {63'h0, ~FAST});
    chk("dz_c1_valid", {63'h0, hilo_valid_o}, {63'h0, FAST});
    if (!hilo_valid_o) begin
      @(negedge clk);
      div_ready_i = 1'b0;
      #1;
    end
    chk("dz_valid", {63'h0, hilo_valid_o}, 64'h1);
    chk("dz_hilo", hilo_o, 64'h00000005_FFFFFFFF);
    chk("dz_err", {63'h0, err_o}, 64'h0);
    start_i = 1'b0; div_ready_i = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-RUN, then DIVU 9/3.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b1; a_i = 32'd123; b_i = 32'd4;
    repeat (5) @(negedge clk);
    #1;
    chk("mid_running", {63'h0, div_start_o}, 64'h1);
    rst = 1'b1; start_i = 1'b0;
    #1;
    chk("arst_start", {63'h0, div_start_o}, 64'h0);
    chk("arst_outs", {60'h0, div_annul_o, stall_o, hilo_valid_o, err_o}, 64'h0);
    chk("arst_ops", {div_a_o, div_b_o}, 64'h0);
    chk("arst_hilo", {63'h0, div_signed_o}, 64'h0);
    chk("arst_res", hilo_o, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd9; b_i = 32'd3;
    wait_done(4, 64'h00000000_00000003, runs, stalls, annuls, annul_at);
    chk("post_rst_hilo", hilo_o, 64'h00000000_00000003);
    chk("post_rst_runs", 64'(runs), 64'd4);
    start_i = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
